// File: rtl/hex_pkg.sv
// ============================================================================
// Module  : hex_pkg
// Purpose : Shared definitions for the hex display blocks: digit count, scan
//           state encoding, the 7-segment glyph table and the leading-zero
//           hide mask helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [0:0] {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } state_t;

    // Glyphs, active-high, bit0 = a ... bit6 = g. Packed so that index n
    // selects the glyph for nibble value n (first entry listed is index 15).
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

    // Bit k set means digit k is a leading zero that must stay dark.
    // Digit 0 is never hidden so a value of zero still shows "0".
    function automatic logic [NUM_DIGITS-1:0] lz_hide_mask(
        input logic [4*NUM_DIGITS-1:0] num,
        input logic                    lz_en
    );
        logic [NUM_DIGITS-1:0] mask;
        logic                  upper_zero;
        mask       = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero & (num[4*k +: 4] == 4'h0);
            mask[k]    = lz_en & upper_zero;
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex7seg_decode.sv
// ============================================================================
// Module  : hex7seg_decode
// Purpose : Combinational hex nibble to 7-segment decoder, active-low output.
// Ports   : nibble_i [3:0]  value 0..F
//           seg_n_o  [6:0]  cathodes, active-low, bit0 = a ... bit6 = g
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex7seg_decode
    import hex_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    assign seg_n_o = ~SEG_LUT[nibble_i];

endmodule

`default_nettype wire

// File: rtl/hex_scan_driver.sv
// ============================================================================
// Module  : hex_scan_driver
// Purpose : Time-multiplexes four common-anode 7-segment digits with
//           dead-time between digits, leading-zero blanking and a per-frame
//           snapshot of the displayed value and controls.
// Ports   : clk_i          system clock
//           rst_i          asynchronous active-high reset
//           number_i[15:0] value, nibble k -> digit k (digit 0 rightmost)
//           digit_en_i[3:0] per-digit enable
//           dp_i[3:0]      per-digit decimal point, active-high
//           lz_blank_i     leading-zero blanking enable
//           seg_o[6:0]     cathodes, active-low
//           dp_o           decimal-point cathode, active-low
//           an_o[3:0]      anodes, active-low
//           frame_o        one-clock pulse at each frame start
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_scan_driver
    import hex_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int DEAD_CYCLES  = 1000
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] number_i,
    input  logic [3:0]  digit_en_i,
    input  logic [3:0]  dp_i,
    input  logic        lz_blank_i,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [3:0]  an_o,
    output logic        frame_o
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > DEAD_CYCLES) ? DIGIT_CYCLES : DEAD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);

    state_t           state_q,  state_d;
    logic [1:0]       idx_q,    idx_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      num_s_q,  num_s_d;
    logic [3:0]       en_s_q,   en_s_d;
    logic [3:0]       dp_s_q,   dp_s_d;
    logic             lz_s_q,   lz_s_d;
    logic [6:0]       seg_q,    seg_d;
    logic             dp_q,     dp_d;
    logic [3:0]       an_q,     an_d;
    logic             frame_q,  frame_d;

    logic [3:0]       digit_nib;
    logic [6:0]       digit_seg_n;
    logic [3:0]       hide_mask;
    logic             digit_visible;

    // ------------------------------------------------------------------
    // Next-state: scan sequencing and frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + CNT_W'(1);
        num_s_d = num_s_q;
        en_s_d  = en_s_q;
        dp_s_d  = dp_s_q;
        lz_s_d  = lz_s_q;
        frame_d = 1'b0;
        case (state_q)
            DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    // Entering digit 0 starts a frame: freeze all display
                    // inputs so one scan never mixes old and new values.
                    if (idx_q == 2'd0) begin
                        num_s_d = number_i;
                        en_s_d  = digit_en_i;
                        dp_s_d  = dp_i;
                        lz_s_d  = lz_blank_i;
                        frame_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == DIGIT_LAST) begin
                    state_d = DEAD;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = DEAD;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode, evaluated on next-state values so the pins change on
    // the same edge as the state and are glitch-free.
    // ------------------------------------------------------------------
    assign digit_nib     = num_s_d[{idx_d, 2'b00} +: 4];
    assign hide_mask     = lz_hide_mask(num_s_d, lz_s_d);
    assign digit_visible = (state_d == DRIVE) && en_s_d[idx_d] && !hide_mask[idx_d];

    hex7seg_decode u_decode (
        .nibble_i (digit_nib),
        .seg_n_o  (digit_seg_n)
    );

    always_comb begin
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (digit_visible) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = digit_seg_n;
            dp_d  = ~dp_s_d[idx_d];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DEAD;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            num_s_q <= 16'h0000;
            en_s_q  <= 4'h0;
            dp_s_q  <= 4'h0;
            lz_s_q  <= 1'b0;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            an_q    <= 4'hF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            num_s_q <= num_s_d;
            en_s_q  <= en_s_d;
            dp_s_q  <= dp_s_d;
            lz_s_q  <= lz_s_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

`default_nettype wire
